// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to the transmitter and
// receiver (so debug probes read the same on both ends), data width and
// default oversampling ratio.
package uart_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int CLKS_PER_BIT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. The reset value is a
// parameter so idle-high lines (e.g. UART Rx) come out of reset idle.
module sync_2ff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Two back-to-back flops; only q is safe to use downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversamples Rx with clk_rx, recovers 8N1 frames and holds
// the last good byte in data_out until the consumer pulses rd_en.
// Optional build macro RX_PARITY_EN switches the frame to 8E1 and adds the
// parity_err output.
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter int  CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic                   clk_rx,
   input  logic                   rst_n,
   input  logic                   Rx,
   input  logic                   rd_en,
   output logic [UART_DATA_W-1:0] data_out,
   output logic                   data_valid,
   output logic                   Rx_busy,
   output logic                   frame_err,
`ifdef RX_PARITY_EN
   output logic                   parity_err,
`endif
   output logic                   overrun,
   output logic [1:0]             state_out
);

`ifdef RX_PARITY_EN
   localparam int FRAME_BITS = UART_DATA_W + 1;  // data plus even parity
   localparam int IDX_W      = 4;
`else
   localparam int FRAME_BITS = UART_DATA_W;
   localparam int IDX_W      = 3;
`endif

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

   uart_state_e             state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [IDX_W-1:0]        bit_idx, idx_nxt;
   logic [FRAME_BITS-1:0]   sh, sh_nxt;
   logic                    rx_s;
   logic                    stop_smp;
   logic                    frame_bad, par_bad, byte_ok, load, drop;

   sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_rx (
      .clk   (clk_rx),
      .rst_n (rst_n),
      .d     (Rx),
      .q     (rx_s)
   );

   // FSM and bit-timing state registers.
   always_ff @(posedge clk_rx or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= idx_nxt;
         sh      <= sh_nxt;
      end
   end

   // Next state, bit-period counting and LSB-first shifting.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = bit_idx;
      sh_nxt    = sh;
      stop_smp  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               cnt_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            // Re-check the line at mid start bit; high means a glitch.
            if (cnt == HALF_M1) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  idx_nxt   = '0;
                  state_nxt = DATA;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_nxt = '0;
               sh_nxt  = {rx_s, sh[FRAME_BITS-1:1]};
               idx_nxt = bit_idx + IDX_W'(1);
               if (bit_idx == LAST_IDX) state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            // Leave at mid stop bit so a following start edge is not missed.
            if (cnt == FULL_M1) begin
               cnt_nxt   = '0;
               stop_smp  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame disposition at the stop sample: frame error beats parity error.
   assign frame_bad = stop_smp & ~rx_s;
`ifdef RX_PARITY_EN
   assign par_bad   = stop_smp & rx_s & (^sh);
`else
   assign par_bad   = 1'b0;
`endif
   assign byte_ok   = stop_smp & rx_s & ~par_bad;
   assign load      = byte_ok & ~data_valid;
   assign drop      = byte_ok &  data_valid;

   // Output holding register, handshake and error flags; a load beats rd_en.
   always_ff @(posedge clk_rx or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         if (load) begin
            data_out   <= sh[UART_DATA_W-1:0];
            data_valid <= 1'b1;
            overrun    <= 1'b0;
         end else begin
            if (rd_en) data_valid <= 1'b0;
            if (drop)       overrun <= 1'b1;
            else if (rd_en) overrun <= 1'b0;
         end
      end
   end

`ifdef RX_PARITY_EN
   // Parity error pulse lines up with where data_valid would have risen.
   always_ff @(posedge clk_rx or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= par_bad;
   end
`endif

   assign Rx_busy   = (state != IDLE);
   assign state_out = state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at CLKS_PER_BIT=16.
module tb_uart_rx_deserializer;

   localparam int CPB = 16;

   logic       clk_rx = 1'b0;
   logic       rst_n  = 1'b0;
   logic       Rx     = 1'b1;
   logic       rd_en  = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, Rx_busy, frame_err, overrun;
   logic [1:0] state_out;
`ifdef RX_PARITY_EN
   logic       parity_err;
   int         pe_cnt = 0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int fe_cnt  = 0;
   int fe0;

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
      .clk_rx     (clk_rx),
      .rst_n      (rst_n),
      .Rx         (Rx),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .Rx_busy    (Rx_busy),
      .frame_err  (frame_err),
`ifdef RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .overrun    (overrun),
      .state_out  (state_out)
   );

   always #5 clk_rx = ~clk_rx;

   // Count high cycles of the error pulses, sampled away from the active edge.
   always @(negedge clk_rx) begin
      if (frame_err) fe_cnt++;
`ifdef RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      Rx = b;
      repeat (CPB) @(negedge clk_rx);
   endtask

   // Start, 8 data bits LSB first, optional parity, stop, then idle gap.
   task automatic send_frame(input logic [7:0] b, input logic par,
                             input logic stop, input int gap);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef RX_PARITY_EN
      bit_out(par);
`endif
      bit_out(stop);
      Rx = 1'b1;
      repeat (gap) @(negedge clk_rx);
   endtask

   task automatic pulse_rd();
      rd_en = 1'b1;
      @(negedge clk_rx);
      rd_en = 1'b0;
      @(negedge clk_rx);
   endtask

   initial begin
      repeat (3) @(negedge clk_rx);
      chk("rst_state", 32'(state_out), 32'h0);
      chk("rst_data",  32'(data_out),  32'h0);
      chk("rst_valid", 32'(data_valid), 32'h0);
      chk("rst_busy",  32'(Rx_busy),   32'h0);
      chk("rst_ovr",   32'(overrun),   32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_rx);

      // Clean byte
      fe0 = fe_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, 4);
      chk("a5_data",  32'(data_out),   32'hA5);
      chk("a5_valid", 32'(data_valid), 32'h1);
      chk("a5_fe",    32'(fe_cnt - fe0), 32'h0);
      chk("a5_state", 32'(state_out),  32'h0);
      pulse_rd();
      chk("a5_rd_valid", 32'(data_valid), 32'h0);

      // Glitch rejection
      Rx = 1'b0;
      repeat (5) @(negedge clk_rx);
      chk("gl_busy_mid", 32'(Rx_busy), 32'h1);
      Rx = 1'b1;
      repeat (20) @(negedge clk_rx);
      chk("gl_state", 32'(state_out),  32'h0);
      chk("gl_busy",  32'(Rx_busy),    32'h0);
      chk("gl_valid", 32'(data_valid), 32'h0);
      chk("gl_fe",    32'(fe_cnt - fe0), 32'h0);

      // Framing error
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 24);
      chk("fe_pulse", 32'(fe_cnt - fe0), 32'h1);
      chk("fe_valid", 32'(data_valid),  32'h0);
      chk("fe_state", 32'(state_out),   32'h0);

      // Back-to-back frames and overrun
      send_frame(8'h11, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 4);
      chk("b2b_data",  32'(data_out),   32'h11);
      chk("b2b_ovr",   32'(overrun),    32'h1);
      chk("b2b_valid", 32'(data_valid), 32'h1);
      pulse_rd();
      chk("b2b_rd_valid", 32'(data_valid), 32'h0);
      chk("b2b_rd_ovr",   32'(overrun),    32'h0);
      send_frame(8'h33, 1'b0, 1'b1, 4);
      chk("b33_data",  32'(data_out),   32'h33);
      chk("b33_valid", 32'(data_valid), 32'h1);

      // Reset during bit 4 of 0xFF
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(1'b1);
      Rx = 1'b1;
      repeat (CPB/2) @(negedge clk_rx);
      chk("rm_busy_pre", 32'(Rx_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rm_state", 32'(state_out),  32'h0);
      chk("rm_data",  32'(data_out),   32'h0);
      chk("rm_valid", 32'(data_valid), 32'h0);
      chk("rm_busy",  32'(Rx_busy),    32'h0);
      chk("rm_fe",    32'(frame_err),  32'h0);
      repeat (3) @(negedge clk_rx);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_rx);
      send_frame(8'h5A, 1'b0, 1'b1, 4);
      chk("r5a_data",  32'(data_out),   32'h5A);
      chk("r5a_valid", 32'(data_valid), 32'h1);
      pulse_rd();

`ifdef RX_PARITY_EN
      // 0x07 has three ones, so even parity bit is 1
      send_frame(8'h07, 1'b1, 1'b1, 4);
      chk("p07_data",  32'(data_out),   32'h07);
      chk("p07_valid", 32'(data_valid), 32'h1);
      pulse_rd();
      begin
         int pe0;
         pe0 = pe_cnt;
         send_frame(8'h07, 1'b0, 1'b1, 4);
         chk("pbad_pulse", 32'(pe_cnt - pe0), 32'h1);
         chk("pbad_valid", 32'(data_valid),  32'h0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
